// File: rtl/gpr_pkg.sv
// Shared defaults and types for the general-purpose register file.
// Optional build macro: GPR_BYPASS_EN (write-to-read bypass).
package gpr_pkg;
   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;
   localparam int AW_DEF   = $clog2(NREG_DEF);

   typedef logic [AW_DEF-1:0]   reg_idx_t;
   typedef logic [XLEN_DEF-1:0] word_t;
endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register pending bits for long-latency destinations, issue stall and pending count.
// Optional build macro: GPR_BYPASS_EN (bits cleared this cycle stop blocking immediately).
module gpr_scoreboard
   import gpr_pkg::*;
#(
   parameter int NREG = NREG_DEF,
   parameter int NRP  = 4,
   parameter int NWP  = 2,
   localparam int AW  = $clog2(NREG),
   localparam int CW  = $clog2(NREG + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NRP-1:0]    rd_valid,
   input  logic [NRP*AW-1:0] rd_addr,
   input  logic [NWP-1:0]    wr_en,
   input  logic [NWP*AW-1:0] wr_addr,
   input  logic [NWP-1:0]    iss_valid,
   input  logic [NWP*AW-1:0] iss_rd,
   output logic              stall,
   output logic [CW-1:0]     pend_cnt
);

   logic [NREG-1:0] pending;
   logic [NREG-1:0] clr;
   logic [NREG-1:0] set;
   logic [NREG-1:0] busy;
   logic [NREG-1:0] pend_nxt;
   logic            stall_c;

   always_comb begin
      clr = '0;
      for (int k = 0; k < NWP; k++)
         if (wr_en[k]) clr[wr_addr[k*AW +: AW]] = 1'b1;
   end

`ifdef GPR_BYPASS_EN
   assign busy = pending & ~clr;
`else
   assign busy = pending;
`endif

   // Any reader or destination hitting a busy register blocks issue (RAW and WAW).
   always_comb begin
      stall_c = 1'b0;
      for (int p = 0; p < NRP; p++)
         if (rd_valid[p] && busy[rd_addr[p*AW +: AW]]) stall_c = 1'b1;
      for (int k = 0; k < NWP; k++)
         if (iss_valid[k] && busy[iss_rd[k*AW +: AW]]) stall_c = 1'b1;
   end

   always_comb begin
      set = '0;
      if (!stall_c)
         for (int k = 0; k < NWP; k++)
            if (iss_valid[k]) set[iss_rd[k*AW +: AW]] = 1'b1;
   end

   // A new producer outranks the completing one on the same index.
   assign pend_nxt = (pending & ~clr) | set;

   always_ff @(posedge clk) begin
      if (rst) pending <= '0;
      else     pending <= pend_nxt;
   end

   always_comb begin
      pend_cnt = '0;
      for (int i = 0; i < NREG; i++)
         pend_cnt = pend_cnt + CW'(pending[i]);
   end

   assign stall = stall_c;

endmodule

// File: rtl/gpr_file.sv
// Multi-ported flop register file with zero-latency reads and a load scoreboard.
// Optional build macro: GPR_BYPASS_EN (same-cycle write data forwarded to reads).
module gpr_file
   import gpr_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NREG = NREG_DEF,
   parameter int NRP  = 4,
   parameter int NWP  = 2,
   localparam int AW  = $clog2(NREG),
   localparam int CW  = $clog2(NREG + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRP-1:0]      rd_valid,
   input  logic [NRP*AW-1:0]   rd_addr,
   output logic [NRP*XLEN-1:0] rd_data,
   input  logic [NWP-1:0]      wr_en,
   input  logic [NWP*AW-1:0]   wr_addr,
   input  logic [NWP*XLEN-1:0] wr_data,
   input  logic [NWP-1:0]      iss_valid,
   input  logic [NWP*AW-1:0]   iss_rd,
   output logic                stall,
   output logic [CW-1:0]       pend_cnt,
   output logic [7:0]          dbg_r0
);

   logic [XLEN-1:0] regs [NREG];

   // Later ports overwrite earlier ones, so the highest port index wins a collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         for (int k = 0; k < NWP; k++)
            if (wr_en[k]) regs[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
      end
   end

   always_comb begin
      rd_data = '0;
      for (int p = 0; p < NRP; p++) begin
         rd_data[p*XLEN +: XLEN] = regs[rd_addr[p*AW +: AW]];
`ifdef GPR_BYPASS_EN
         for (int k = 0; k < NWP; k++)
            if (wr_en[k] && (wr_addr[k*AW +: AW] == rd_addr[p*AW +: AW]))
               rd_data[p*XLEN +: XLEN] = wr_data[k*XLEN +: XLEN];
`endif
      end
   end

   assign dbg_r0 = regs[0][7:0];

   gpr_scoreboard #(
      .NREG (NREG),
      .NRP  (NRP),
      .NWP  (NWP)
   ) u_sb (
      .clk       (clk),
      .rst       (rst),
      .rd_valid  (rd_valid),
      .rd_addr   (rd_addr),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .stall     (stall),
      .pend_cnt  (pend_cnt)
   );

endmodule

// File: tb/tb_gpr_file.sv
// Directed self-checking bench for gpr_file at default parameters.
module tb_gpr_file;
   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NRP  = 4;
   localparam int NWP  = 2;
   localparam int AW   = 5;
   localparam int CW   = 6;

   logic                clk = 1'b0;
   logic                rst;
   logic [NRP-1:0]      rd_valid;
   logic [NRP*AW-1:0]   rd_addr;
   logic [NRP*XLEN-1:0] rd_data;
   logic [NWP-1:0]      wr_en;
   logic [NWP*AW-1:0]   wr_addr;
   logic [NWP*XLEN-1:0] wr_data;
   logic [NWP-1:0]      iss_valid;
   logic [NWP*AW-1:0]   iss_rd;
   logic                stall;
   logic [CW-1:0]       pend_cnt;
   logic [7:0]          dbg_r0;

   int n_chk = 0;
   int n_err = 0;

   gpr_file #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP)) dut (
      .clk(clk), .rst(rst), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid),
      .iss_rd(iss_rd), .stall(stall), .pend_cnt(pend_cnt), .dbg_r0(dbg_r0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      rd_valid  = '0;
      rd_addr   = '0;
      wr_en     = '0;
      wr_addr   = '0;
      wr_data   = '0;
      iss_valid = '0;
      iss_rd    = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input int p, input logic [AW-1:0] a, input logic v);
      rd_addr[p*AW +: AW] = a;
      rd_valid[p]         = v;
   endtask

   task automatic wr(input int k, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      wr_en[k]                = 1'b1;
      wr_addr[k*AW +: AW]     = a;
      wr_data[k*XLEN +: XLEN] = d;
   endtask

   task automatic iss(input int k, input logic [AW-1:0] a);
      iss_valid[k]       = 1'b1;
      iss_rd[k*AW +: AW] = a;
   endtask

   function automatic logic [XLEN-1:0] rdp(input int p);
      return rd_data[p*XLEN +: XLEN];
   endfunction

   initial begin
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("reset_pend_cnt", 64'(pend_cnt), 64'd0);
      chk("reset_stall", 64'(stall), 64'd0);
      chk("reset_dbg_r0", 64'(dbg_r0), 64'd0);
      rd(0, 5'd0, 1'b0);
      #1;
      chk("reset_r0", 64'(rdp(0)), 64'd0);

      // single write, visible on every read port next cycle
      idle();
      wr(0, 5'd5, 32'h1234);
      rd(0, 5'd5, 1'b1);
      #1;
`ifdef GPR_BYPASS_EN
      chk("r5_same_cycle", 64'(rdp(0)), 64'h1234);
`else
      chk("r5_same_cycle", 64'(rdp(0)), 64'h0);
`endif
      tick();
      idle();
      for (int p = 0; p < NRP; p++) rd(p, 5'd5, 1'b1);
      #1;
      for (int p = 0; p < NRP; p++) chk($sformatf("r5_port%0d", p), 64'(rdp(p)), 64'h1234);

      // write collision: higher port wins
      idle();
      wr(0, 5'd7, 32'hA);
      wr(1, 5'd7, 32'hB);
      tick();
      idle();
      rd(2, 5'd7, 1'b1);
      #1;
      chk("r7_collision", 64'(rdp(2)), 64'hB);

      // r0 is an ordinary register and drives the LEDs
      idle();
      wr(1, 5'd0, 32'hA5C3);
      tick();
      idle();
      rd(3, 5'd0, 1'b1);
      #1;
      chk("r0_not_zero", 64'(rdp(3)), 64'hA5C3);
      chk("dbg_r0", 64'(dbg_r0), 64'hC3);

      // load to r3, dependent read stalls until write-back
      idle();
      iss(0, 5'd3);
      #1;
      chk("iss_r3_no_stall", 64'(stall), 64'd0);
      tick();
      idle();
      rd(1, 5'd3, 1'b1);
      #1;
      chk("r3_pend_cnt", 64'(pend_cnt), 64'd1);
      chk("r3_raw_stall", 64'(stall), 64'd1);
      wr(0, 5'd3, 32'h55);
      #1;
`ifdef GPR_BYPASS_EN
      chk("r3_wb_stall", 64'(stall), 64'd0);
      chk("r3_wb_data", 64'(rdp(1)), 64'h55);
`else
      chk("r3_wb_stall", 64'(stall), 64'd1);
      chk("r3_wb_data", 64'(rdp(1)), 64'h0);
`endif
      tick();
      wr_en = '0;
      #1;
      chk("r3_after_stall", 64'(stall), 64'd0);
      chk("r3_after_data", 64'(rdp(1)), 64'h55);
      chk("r3_after_cnt", 64'(pend_cnt), 64'd0);

      // issue blocked while stalled does not mark its destination
      idle();
      iss(0, 5'd8);
      tick();
      idle();
      rd(0, 5'd8, 1'b1);
      iss(1, 5'd4);
      #1;
      chk("r8_stall", 64'(stall), 64'd1);
      tick();
      idle();
      rd(0, 5'd4, 1'b1);
      #1;
      chk("r4_blocked_cnt", 64'(pend_cnt), 64'd1);
      chk("r4_not_pending", 64'(stall), 64'd0);
      idle();
      iss(1, 5'd8);
      #1;
      chk("r8_waw_stall", 64'(stall), 64'd1);
      tick();
      idle();
      #1;
      chk("r8_waw_cnt", 64'(pend_cnt), 64'd1);

      // same-cycle set and clear of r9: set wins
      idle();
      wr(0, 5'd9, 32'h99);
      iss(0, 5'd9);
      #1;
      chk("r9_set_clr_stall", 64'(stall), 64'd0);
      tick();
      idle();
      rd(0, 5'd9, 1'b1);
      #1;
      chk("r9_set_cnt", 64'(pend_cnt), 64'd2);
      chk("r9_pending", 64'(stall), 64'd1);
      chk("r9_data", 64'(rdp(0)), 64'h99);

      // r9 already pending: write and re-issue in one cycle
      idle();
      wr(1, 5'd9, 32'h9A);
      iss(0, 5'd9);
      #1;
`ifdef GPR_BYPASS_EN
      chk("r9_reissue_stall", 64'(stall), 64'd0);
`else
      chk("r9_reissue_stall", 64'(stall), 64'd1);
`endif
      tick();
      idle();
      #1;
`ifdef GPR_BYPASS_EN
      chk("r9_reissue_cnt", 64'(pend_cnt), 64'd2);
`else
      chk("r9_reissue_cnt", 64'(pend_cnt), 64'd1);
`endif

      // pending r1,r2 then reset in a cycle that also writes and issues
      idle();
      iss(0, 5'd1);
      iss(1, 5'd2);
      tick();
      idle();
      #1;
`ifdef GPR_BYPASS_EN
      chk("r1r2_cnt", 64'(pend_cnt), 64'd4);
`else
      chk("r1r2_cnt", 64'(pend_cnt), 64'd3);
`endif
      rst = 1'b1;
      wr(0, 5'd1, 32'hDEAD);
      iss(1, 5'd10);
      tick();
      rst = 1'b0;
      idle();
      rd(0, 5'd1, 1'b1);
      rd(1, 5'd0, 1'b1);
      rd(2, 5'd5, 1'b1);
      rd(3, 5'd10, 1'b1);
      #1;
      chk("rst_pend_cnt", 64'(pend_cnt), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_dbg_r0", 64'(dbg_r0), 64'd0);
      chk("rst_r1", 64'(rdp(0)), 64'd0);
      chk("rst_r0", 64'(rdp(1)), 64'd0);
      chk("rst_r5", 64'(rdp(2)), 64'd0);

      // a late write after reset is an ordinary write
      idle();
      wr(0, 5'd1, 32'h77);
      tick();
      idle();
      rd(2, 5'd1, 1'b1);
      #1;
      chk("late_wr_data", 64'(rdp(2)), 64'h77);
      chk("late_wr_cnt", 64'(pend_cnt), 64'd0);
      chk("late_wr_stall", 64'(stall), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/gpr_file.md
GPR_FILE -- requirements
Module: gpr_file

Interface
REQ-001 SHALL accept parameter XLEN, default 32, meaning register data width.
REQ-002 SHALL accept parameter NREG, default 32, meaning register count (power of two, >=2).
REQ-003 SHALL accept parameter NRP, default 4, meaning read-port count (two per issue lane).
REQ-004 SHALL accept parameter NWP, default 2, meaning write-port count and issue-lane count.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 rd_valid  input  NRP  per-port read request.
REQ-009 rd_addr  input  NRP x log2(NREG)  per-port read index.
REQ-010 rd_data  output  NRP x XLEN  per-port read data.
REQ-011 wr_en  input  NWP  per-port write strobe.
REQ-012 wr_addr  input  NWP x log2(NREG)  per-port write index.
REQ-013 wr_data  input  NWP x XLEN  per-port write data.
REQ-014 iss_valid  input  NWP  lane issues an instruction with a long-latency (load) destination.
REQ-015 iss_rd  input  NWP x log2(NREG)  destination index per lane.
REQ-016 stall  output  1  issue must hold this cycle.
REQ-017 pend_cnt  output  log2(NREG+1)  number of pending registers.
REQ-018 dbg_r0  output  8  gpr[0][7:0] for board LEDs.

Function
REQ-019 SHALL hold NREG x XLEN registers in flops; no register is hard-wired to zero.
REQ-020 SHALL return rd_data combinationally from current register contents (zero-cycle read latency).
REQ-021 SHALL update register wr_addr[k] with wr_data[k] at the clock edge when wr_en[k]=1.
REQ-022 Two write ports targeting one index in one cycle: the higher port index SHALL win.
REQ-023 SHALL keep one pending bit per register; set at edge when iss_valid[k]=1 and stall=0; cleared at edge when any wr_en targets it.
REQ-024 Same-cycle set and clear of one index: set SHALL win (newer producer).
REQ-025 stall SHALL be 1 when any rd_valid port, or any iss_valid lane's iss_rd, addresses a pending register (RAW and WAW), else 0.
REQ-026 While stall=1, iss_valid SHALL NOT set any pending bit.
REQ-027 pend_cnt SHALL equal popcount of pending bits after each edge, saturating never needed (max NREG).
REQ-028 dbg_r0 SHALL always reflect gpr[0][7:0].

Reset
REQ-029 rst=1 at an edge SHALL clear all registers, all pending bits and pend_cnt to 0; writes and issues that cycle are discarded.
REQ-030 Reset mid-operation SHALL drop outstanding pending bits; a late write after reset behaves as an ordinary write.
REQ-031 stall SHALL be 0 in the cycle after reset.

Configuration
REQ-032 Macro GPR_BYPASS_EN SHALL select write-to-read bypass.
REQ-033 With GPR_BYPASS_EN: a read of an index written this cycle returns wr_data (highest port wins), and a pending bit being cleared this cycle does not raise stall.
REQ-034 Without GPR_BYPASS_EN: reads return pre-edge contents; stall persists until the cycle after the clearing write.

Structure
REQ-035 Package gpr_pkg SHALL hold XLEN/NREG defaults and typedefs for register index and data word.
REQ-036 Pending-bit logic, stall and pend_cnt SHALL live in sub-module gpr_scoreboard; storage and bypass stay in gpr_file.

Verification
REQ-037 Write port0 r5=0x1234 -> next cycle read r5 on any port = 0x1234.
REQ-038 Port0 and port1 both write r7 (0xA, 0xB) -> r7=0xB.
REQ-039 Issue load r3, then read r3 -> stall=1, pend_cnt=1; write r3=0x55 -> with bypass stall=0 same cycle, data 0x55; without bypass stall=0 next cycle.
REQ-040 Issue r9 on lane0 while r9 write clears same cycle -> r9 remains pending, pend_cnt unchanged.
REQ-041 stall=1 with iss_valid r4 -> r4 not marked pending, pend_cnt unchanged.
REQ-042 Pending r1,r2 then rst=1 -> pend_cnt=0, stall=0, all registers 0, dbg_r0=0.
